// File: rtl/ahblite_slavearbiter_param_if.sv
// rtl/ahblite_slavearbiter_param_if.sv - request/grant bundle between masters and one slave arbiter
interface ahblite_slavearbiter_param_if #(
    parameter int NUM_MASTERS = 4,
    parameter int IDXW        = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
);
    logic [NUM_MASTERS-1:0] MADDRSEL;
    logic                   ADDRPHEND;
    logic [NUM_MASTERS-1:0] MGATEDHMASTLOCK;
    logic [NUM_MASTERS-1:0] MASTERADDRINPROG;
    logic [IDXW-1:0]        OWNER;
    logic                   LOCKTIMEOUT;

    modport master (
        output MADDRSEL, ADDRPHEND, MGATEDHMASTLOCK,
        input  MASTERADDRINPROG, OWNER, LOCKTIMEOUT
    );

    modport slave (
        input  MADDRSEL, ADDRPHEND, MGATEDHMASTLOCK,
        output MASTERADDRINPROG, OWNER, LOCKTIMEOUT
    );
endinterface

// File: rtl/ahblite_slavearbiter_param.sv
// rtl/ahblite_slavearbiter_param.sv - per-slave address-phase arbiter, round-robin or fixed priority
module ahblite_slavearbiter_param #(
    parameter int NUM_MASTERS   = 4,
    parameter int PRIORITY_MODE = 0,
    parameter int LOCK_TIMEOUT  = 0
) (
    input  logic                         HCLK,
    input  logic                         aresetn,
    ahblite_slavearbiter_param_if.slave  bus
);
    localparam int              IDXW      = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [IDXW-1:0] OWNER_RST = IDXW'(NUM_MASTERS - 1);
    localparam logic [15:0]     LT        = 16'(LOCK_TIMEOUT);

    typedef enum logic [1:0] {
        ST_DONE       = 2'd0,
        ST_EXTEND     = 2'd1,
        ST_LOCK       = 2'd2,
        ST_LOCKEXTEND = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [IDXW-1:0]        owner_q, owner_d;
    logic [15:0]            lock_cnt_q, lock_cnt_d;
    logic                   locktimeout_q, locktimeout_d;
    logic [NUM_MASTERS-1:0] grant;
    logic                   found;
    logic [IDXW-1:0]        win;
    logic [IDXW-1:0]        cand;
    logic                   lock_state;

    // Round-robin search starts just past the last owner and ends on it.
    always_comb begin
        found = 1'b0;
        win   = owner_q;
        cand  = '0;
        if (PRIORITY_MODE == 1) begin
            for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
                if (bus.MADDRSEL[i]) begin
                    found = 1'b1;
                    win   = IDXW'(i);
                end
            end
        end else begin
            for (int i = 1; i <= NUM_MASTERS; i++) begin
                cand = IDXW'((int'(owner_q) + i) % NUM_MASTERS);
                if (!found && bus.MADDRSEL[cand]) begin
                    found = 1'b1;
                    win   = cand;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        grant   = '0;
        case (state_q)
            ST_DONE: begin
                if (found) begin
                    owner_d = win;
                    if (bus.MGATEDHMASTLOCK[win]) begin
                        state_d = ST_LOCK;
                    end else begin
                        grant[win] = 1'b1;
                        state_d    = bus.ADDRPHEND ? ST_DONE : ST_EXTEND;
                    end
                end
            end
            ST_EXTEND: begin
                grant[owner_q] = 1'b1;
                if (bus.ADDRPHEND) state_d = ST_DONE;
            end
            ST_LOCK: begin
                if (!bus.MGATEDHMASTLOCK[owner_q]) begin
                    state_d = ST_DONE;
                end else if (bus.MADDRSEL[owner_q]) begin
                    grant[owner_q] = 1'b1;
                    if (!bus.ADDRPHEND) state_d = ST_LOCKEXTEND;
                end
            end
            ST_LOCKEXTEND: begin
                grant[owner_q] = 1'b1;
                if (bus.ADDRPHEND) state_d = ST_LOCK;
            end
            default: state_d = ST_DONE;
        endcase
    end

    // Watchdog saturates, so the edge into LT happens once per lock tenure.
    always_comb begin
        lock_state    = (state_q == ST_LOCK) || (state_q == ST_LOCKEXTEND);
        lock_cnt_d    = lock_cnt_q;
        locktimeout_d = 1'b0;
        if ((LOCK_TIMEOUT == 0) || !lock_state) begin
            lock_cnt_d = '0;
        end else if (lock_cnt_q != LT) begin
            lock_cnt_d    = lock_cnt_q + 16'd1;
            locktimeout_d = (lock_cnt_d == LT);
        end
    end

    always_ff @(posedge HCLK or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= ST_DONE;
            owner_q       <= OWNER_RST;
            lock_cnt_q    <= '0;
            locktimeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            lock_cnt_q    <= lock_cnt_d;
            locktimeout_q <= locktimeout_d;
        end
    end

    assign bus.MASTERADDRINPROG = aresetn ? grant : '0;
    assign bus.OWNER            = owner_q;
    assign bus.LOCKTIMEOUT      = locktimeout_q;

endmodule

// File: tb/tb_ahblite_slavearbiter_param.sv
// tb/tb_ahblite_slavearbiter_param.sv - directed bench for round-robin and fixed-priority arbiters
module tb_ahblite_slavearbiter_param;
    logic       HCLK;
    logic       aresetn;
    logic [3:0] maddrsel;
    logic       addrphend;
    logic [3:0] lock;
    int         vectors;
    int         miscompares;

    ahblite_slavearbiter_param_if #(.NUM_MASTERS(4)) bus0 ();
    ahblite_slavearbiter_param_if #(.NUM_MASTERS(4)) bus1 ();

    assign bus0.MADDRSEL        = maddrsel;
    assign bus0.ADDRPHEND       = addrphend;
    assign bus0.MGATEDHMASTLOCK = lock;
    assign bus1.MADDRSEL        = maddrsel;
    assign bus1.ADDRPHEND       = addrphend;
    assign bus1.MGATEDHMASTLOCK = lock;

    ahblite_slavearbiter_param #(.NUM_MASTERS(4), .PRIORITY_MODE(0), .LOCK_TIMEOUT(5)) dut_rr (
        .HCLK    (HCLK),
        .aresetn (aresetn),
        .bus     (bus0)
    );

    ahblite_slavearbiter_param #(.NUM_MASTERS(4), .PRIORITY_MODE(1), .LOCK_TIMEOUT(0)) dut_fp (
        .HCLK    (HCLK),
        .aresetn (aresetn),
        .bus     (bus1)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic cyc(input logic [3:0] s, input logic p, input logic [3:0] l);
        @(negedge HCLK);
        maddrsel  = s;
        addrphend = p;
        lock      = l;
        #1;
    endtask

    task automatic test_reset;
        aresetn = 1'b0; maddrsel = 4'b1111; addrphend = 1'b1; lock = 4'b0000;
        repeat (2) @(posedge HCLK);
        @(negedge HCLK); #1;
        vectors++;
        if (bus0.MASTERADDRINPROG !== 4'b0000) begin
            miscompares++; $display("FAIL reset_grant_rr got=%b exp=0000", bus0.MASTERADDRINPROG);
        end
        vectors++;
        if (bus1.MASTERADDRINPROG !== 4'b0000) begin
            miscompares++; $display("FAIL reset_grant_fp got=%b exp=0000", bus1.MASTERADDRINPROG);
        end
        vectors++;
        if (bus0.OWNER !== 2'd3) begin
            miscompares++; $display("FAIL reset_owner got=%0d exp=3", bus0.OWNER);
        end
        vectors++;
        if (bus0.LOCKTIMEOUT !== 1'b0) begin
            miscompares++; $display("FAIL reset_locktimeout got=%b exp=0", bus0.LOCKTIMEOUT);
        end
        @(negedge HCLK);
        aresetn = 1'b1; maddrsel = 4'b0000;
        #1;
        vectors++;
        if (bus0.MASTERADDRINPROG !== 4'b0000 || bus0.OWNER !== 2'd3) begin
            miscompares++;
            $display("FAIL reset_idle got grant=%b owner=%0d exp grant=0000 owner=3", bus0.MASTERADDRINPROG, bus0.OWNER);
        end
    endtask

    task automatic test_rr_fairness;
        logic [3:0] exp_g;
        logic [1:0] exp_o;
        for (int c = 0; c < 8; c++) begin
            cyc(4'b1111, 1'b1, 4'b0000);
            exp_g = 4'b0001 << (c % 4);
            exp_o = 2'((c + 3) % 4);
            vectors++;
            if (bus0.MASTERADDRINPROG !== exp_g) begin
                miscompares++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, bus0.MASTERADDRINPROG, exp_g);
            end
            vectors++;
            if (bus0.OWNER !== exp_o) begin
                miscompares++; $display("FAIL rr_owner c=%0d got=%0d exp=%0d", c, bus0.OWNER, exp_o);
            end
        end
    endtask

    task automatic test_fixed_priority;
        cyc(4'b1110, 1'b1, 4'b0000);
        vectors++;
        if (bus1.MASTERADDRINPROG !== 4'b0010) begin
            miscompares++; $display("FAIL fp_1110 got=%b exp=0010", bus1.MASTERADDRINPROG);
        end
        cyc(4'b1111, 1'b1, 4'b0000);
        vectors++;
        if (bus1.MASTERADDRINPROG !== 4'b0001 || bus1.OWNER !== 2'd1) begin
            miscompares++;
            $display("FAIL fp_1111 got grant=%b owner=%0d exp grant=0001 owner=1", bus1.MASTERADDRINPROG, bus1.OWNER);
        end
        cyc(4'b1000, 1'b1, 4'b0000);
        vectors++;
        if (bus1.MASTERADDRINPROG !== 4'b1000) begin
            miscompares++; $display("FAIL fp_1000 got=%b exp=1000", bus1.MASTERADDRINPROG);
        end
    endtask

    task automatic test_extension;
        cyc(4'b0100, 1'b0, 4'b0000);
        vectors++;
        if (bus0.MASTERADDRINPROG !== 4'b0100) begin
            miscompares++; $display("FAIL ext_c0 got=%b exp=0100", bus0.MASTERADDRINPROG);
        end
        for (int c = 1; c < 4; c++) begin
            cyc(4'b0101, (c == 3), 4'b0000);
            vectors++;
            if (bus0.MASTERADDRINPROG !== 4'b0100 || bus0.OWNER !== 2'd2) begin
                miscompares++;
                $display("FAIL ext_hold c=%0d got grant=%b owner=%0d exp grant=0100 owner=2", c, bus0.MASTERADDRINPROG, bus0.OWNER);
            end
        end
        cyc(4'b0001, 1'b1, 4'b0000);
        vectors++;
        if (bus0.MASTERADDRINPROG !== 4'b0001) begin
            miscompares++; $display("FAIL ext_next got=%b exp=0001", bus0.MASTERADDRINPROG);
        end
        cyc(4'b0000, 1'b1, 4'b0000);
    endtask

    task automatic test_lock;
        logic [3:0] sel_v  [8] = '{4'b0010, 4'b0011, 4'b0011, 4'b0001, 4'b0011, 4'b0001, 4'b0001, 4'b0001};
        logic       end_v  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [3:0] lock_v [8] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
        logic [3:0] exp_v  [8] = '{4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0001};
        for (int c = 0; c < 8; c++) begin
            cyc(sel_v[c], end_v[c], lock_v[c]);
            vectors++;
            if (bus0.MASTERADDRINPROG !== exp_v[c]) begin
                miscompares++; $display("FAIL lock_grant c=%0d got=%b exp=%b", c, bus0.MASTERADDRINPROG, exp_v[c]);
            end
            if (c == 1) begin
                vectors++;
                if (bus0.OWNER !== 2'd1) begin
                    miscompares++; $display("FAIL lock_owner got=%0d exp=1", bus0.OWNER);
                end
            end
        end
        cyc(4'b0000, 1'b1, 4'b0000);
    endtask

    task automatic test_watchdog;
        logic exp_lt;
        cyc(4'b1000, 1'b1, 4'b1000);
        vectors++;
        if (bus0.MASTERADDRINPROG !== 4'b0000 || bus0.LOCKTIMEOUT !== 1'b0) begin
            miscompares++;
            $display("FAIL wd_entry got grant=%b lt=%b exp grant=0000 lt=0", bus0.MASTERADDRINPROG, bus0.LOCKTIMEOUT);
        end
        for (int t = 1; t <= 10; t++) begin
            cyc(4'b1000, 1'b1, 4'b1000);
            exp_lt = (t == 6);
            vectors++;
            if (bus0.LOCKTIMEOUT !== exp_lt) begin
                miscompares++; $display("FAIL wd_pulse t=%0d got=%b exp=%b", t, bus0.LOCKTIMEOUT, exp_lt);
            end
            vectors++;
            if (bus0.MASTERADDRINPROG !== 4'b1000) begin
                miscompares++; $display("FAIL wd_hold t=%0d got=%b exp=1000", t, bus0.MASTERADDRINPROG);
            end
        end
        cyc(4'b0000, 1'b1, 4'b0000);
    endtask

    task automatic test_reset_mid;
        cyc(4'b0010, 1'b1, 4'b0010);
        cyc(4'b0010, 1'b0, 4'b0010);
        cyc(4'b1111, 1'b0, 4'b0010);
        vectors++;
        if (bus0.MASTERADDRINPROG !== 4'b0010 || bus0.OWNER !== 2'd1) begin
            miscompares++;
            $display("FAIL rst_pre got grant=%b owner=%0d exp grant=0010 owner=1", bus0.MASTERADDRINPROG, bus0.OWNER);
        end
        #1 aresetn = 1'b0;
        #1;
        vectors++;
        if (bus0.MASTERADDRINPROG !== 4'b0000 || bus0.OWNER !== 2'd3) begin
            miscompares++;
            $display("FAIL rst_async got grant=%b owner=%0d exp grant=0000 owner=3", bus0.MASTERADDRINPROG, bus0.OWNER);
        end
        @(posedge HCLK);
        @(negedge HCLK);
        aresetn = 1'b1; maddrsel = 4'b1111; addrphend = 1'b1; lock = 4'b0000;
        #1;
        vectors++;
        if (bus0.MASTERADDRINPROG !== 4'b0001 || bus0.OWNER !== 2'd3) begin
            miscompares++;
            $display("FAIL rst_first got grant=%b owner=%0d exp grant=0001 owner=3", bus0.MASTERADDRINPROG, bus0.OWNER);
        end
        cyc(4'b0000, 1'b1, 4'b0000);
        vectors++;
        if (bus0.OWNER !== 2'd0) begin
            miscompares++; $display("FAIL rst_owner_after got=%0d exp=0", bus0.OWNER);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_rr_fairness();
        test_fixed_priority();
        test_extension();
        test_lock();
        test_watchdog();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
